// File: rtl/lsb_pkg.sv
// Shared types and constants for the two-load / two-store reservation buffer.
package lsb_pkg;

  localparam int TAG_W = 4;

  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t TAG_NONE  = '0;
  localparam tag_t LOAD1_TAG = 4'd9;
  localparam tag_t LOAD2_TAG = 4'd10;

  typedef struct packed {
    logic        busy;
    tag_t        qbase;
    logic [31:0] vbase;
    logic [31:0] imm;
    tag_t        qdata;
    logic [31:0] vdata;
  } lsb_entry_t;

  // True when the CDB is delivering the value an operand is waiting for.
  function automatic logic cdb_hit(input logic cdb_valid, input tag_t cdb_tag, input tag_t q);
    return cdb_valid && (q != TAG_NONE) && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/lsb_entry.sv
// One reservation entry: allocation, CDB operand capture and effective-address add.
// Load entries (IS_STORE = 0) keep their data operand permanently resolved.
module lsb_entry
  import lsb_pkg::*;
#(
  parameter bit IS_STORE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic              retire,
  input  logic [TAG_W-1:0]  alloc_qbase,
  input  logic [31:0]       alloc_vbase,
  input  logic [31:0]       alloc_imm,
  input  logic [TAG_W-1:0]  alloc_qdata,
  input  logic [31:0]       alloc_vdata,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [31:0]       cdb_data,
  output logic              busy,
  output logic              base_rdy,
  output logic              data_rdy,
  output logic [31:0]       addr,
  output logic [31:0]       data
);

  lsb_entry_t ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (ent_q.busy) begin
      if (cdb_hit(cdb_valid, cdb_tag, ent_q.qbase)) begin
        ent_d.qbase = TAG_NONE;
        ent_d.vbase = cdb_data;
      end
      if (cdb_hit(cdb_valid, cdb_tag, ent_q.qdata)) begin
        ent_d.qdata = TAG_NONE;
        ent_d.vdata = cdb_data;
      end
      if (retire) begin
        ent_d.busy = 1'b0;
      end
    end else if (alloc) begin
      // A producer broadcasting in the issue cycle would otherwise be missed.
      ent_d.busy  = 1'b1;
      ent_d.imm   = alloc_imm;
      ent_d.qbase = cdb_hit(cdb_valid, cdb_tag, alloc_qbase) ? TAG_NONE : alloc_qbase;
      ent_d.vbase = cdb_hit(cdb_valid, cdb_tag, alloc_qbase) ? cdb_data : alloc_vbase;
      ent_d.qdata = cdb_hit(cdb_valid, cdb_tag, alloc_qdata) ? TAG_NONE : alloc_qdata;
      ent_d.vdata = cdb_hit(cdb_valid, cdb_tag, alloc_qdata) ? cdb_data : alloc_vdata;
    end
    if (!IS_STORE) begin
      ent_d.qdata = TAG_NONE;
      ent_d.vdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign busy     = ent_q.busy;
  assign base_rdy = (ent_q.qbase == TAG_NONE);
  assign data_rdy = (ent_q.qdata == TAG_NONE);
  assign addr     = ent_q.vbase + ent_q.imm;
  assign data     = ent_q.vdata;

endmodule

// File: rtl/load_store_buffer.sv
// Two-load / two-store reservation buffer feeding the address unit.
// Optional LSB_MEM_ORDER_EN: loads are held until every store older than them has retired.
module load_store_buffer
  import lsb_pkg::*;
#(
  parameter logic [TAG_W-1:0] LOAD1_TAG_P = lsb_pkg::LOAD1_TAG,
  parameter logic [TAG_W-1:0] LOAD2_TAG_P = lsb_pkg::LOAD2_TAG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_is_store,
  input  logic [TAG_W-1:0]  issue_base_tag,
  input  logic [31:0]       issue_base_val,
  input  logic [TAG_W-1:0]  issue_data_tag,
  input  logic [31:0]       issue_data_val,
  input  logic [31:0]       issue_imm,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [31:0]       cdb_data,
  output logic              load1_valid,
  output logic              load2_valid,
  output logic [TAG_W-1:0]  load1_tag,
  output logic [TAG_W-1:0]  load2_tag,
  output logic [31:0]       load1_addr,
  output logic [31:0]       load2_addr,
  output logic              store1_valid,
  output logic              store2_valid,
  output logic [31:0]       store1_addr,
  output logic [31:0]       store2_addr,
  output logic [31:0]       store1_data,
  output logic [31:0]       store2_data
);

  // Entry index: 0 = L1, 1 = L2, 2 = S1, 3 = S2.
  logic [3:0]  busy, base_rdy, data_rdy, alloc, retire, resolved;
  logic [31:0] addr_w [4];
  logic [31:0] data_w [4];
  logic [1:0]  ld_valid, st_valid;
  logic        accept;

  for (genvar gi = 0; gi < 4; gi++) begin : g_entry
    lsb_entry #(.IS_STORE(gi >= 2)) u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc       (alloc[gi]),
      .retire      (retire[gi]),
      .alloc_qbase (issue_base_tag),
      .alloc_vbase (issue_base_val),
      .alloc_imm   (issue_imm),
      .alloc_qdata (issue_data_tag),
      .alloc_vdata (issue_data_val),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .busy        (busy[gi]),
      .base_rdy    (base_rdy[gi]),
      .data_rdy    (data_rdy[gi]),
      .addr        (addr_w[gi]),
      .data        (data_w[gi])
    );
    assign resolved[gi] = busy[gi] && base_rdy[gi] && data_rdy[gi];
  end

  always_comb begin
    issue_ready = issue_is_store ? (!busy[2] || !busy[3]) : (!busy[0] || !busy[1]);
    accept      = issue_valid && issue_ready;
    alloc       = '0;
    issue_tag   = TAG_NONE;
    if (accept) begin
      if (issue_is_store) begin
        alloc[2] = !busy[2];
        alloc[3] = busy[2];
      end else begin
        alloc[0]  = !busy[0];
        alloc[1]  = busy[0];
        issue_tag = busy[0] ? LOAD2_TAG_P : LOAD1_TAG_P;
      end
    end
  end

`ifdef LSB_MEM_ORDER_EN
  logic [1:0] older_q [2];
  logic [1:0] older_d [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      older_d[i] = older_q[i] & ~retire[3:2];
      if (alloc[i]) begin
        older_d[i] = busy[3:2] & ~retire[3:2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older_q[0] <= '0;
      older_q[1] <= '0;
    end else begin
      older_q[0] <= older_d[0];
      older_q[1] <= older_d[1];
    end
  end

  assign ld_valid[0] = resolved[0] && (older_q[0] == 2'b00);
  assign ld_valid[1] = resolved[1] && (older_q[1] == 2'b00);
`else
  assign ld_valid = resolved[1:0];
`endif

  assign st_valid = resolved[3:2];

  // Store retirement follows the address unit's grant order: loads, then S1, then S2.
  always_comb begin
    retire[0] = cdb_valid && (cdb_tag == LOAD1_TAG_P) && busy[0];
    retire[1] = cdb_valid && (cdb_tag == LOAD2_TAG_P) && busy[1];
    retire[2] = st_valid[0] && (ld_valid == 2'b00);
    retire[3] = st_valid[1] && !st_valid[0] && (ld_valid == 2'b00);
  end

  assign load1_valid  = ld_valid[0];
  assign load2_valid  = ld_valid[1];
  assign load1_tag    = LOAD1_TAG_P;
  assign load2_tag    = LOAD2_TAG_P;
  assign load1_addr   = addr_w[0];
  assign load2_addr   = addr_w[1];
  assign store1_valid = st_valid[0];
  assign store2_valid = st_valid[1];
  assign store1_addr  = addr_w[2];
  assign store2_addr  = addr_w[3];
  assign store1_data  = data_w[2];
  assign store2_data  = data_w[3];

endmodule
